// File: rtl/rotary_quad_gen.sv
// rotary_quad_gen: replays rotary-encoder activity as clean Rot_A/Rot_B/Rot_C waveforms.
// A command requests N detents in one direction or a single push-button press.
// Each detent is four quadrature phases followed by an idle-high gap that lets the
// downstream decoder finish its cooldown. All outputs are driven directly from flops.
module rotary_quad_gen #(
  parameter int PHASE_CYCLES = 64,
  parameter int GAP_CYCLES   = 512,
  parameter int CNT_W        = 8
) (
  input  logic             Fg_clk,
  input  logic             Reset,
  input  logic             Cmd_valid,
  output logic             Cmd_ready,
  input  logic             Cmd_dir,
  input  logic [CNT_W-1:0] Cmd_count,
  input  logic             Cmd_press,
  output logic             Rot_A,
  output logic             Rot_B,
  output logic             Rot_C,
  output logic             Busy,
  output logic             Done
);

  localparam int MAX_CYC = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] PHASE_LAST = TMR_W'(PHASE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PH1   = 3'd1,
    S_PH2   = 3'd2,
    S_PH3   = 3'd3,
    S_PH4   = 3'd4,
    S_GAP   = 3'd5,
    S_PRESS = 3'd6
  } state_t;

  state_t           state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic             dir, dir_next;
  logic             a_next, b_next, c_next, busy_next, done_next;

  // Next-state, counters and the output levels that the flops will take next.
  always_comb begin
    state_next     = state;
    timer_next     = timer + 1'b1;
    remaining_next = remaining;
    dir_next       = dir;
    done_next      = 1'b0;

    case (state)
      S_IDLE: begin
        timer_next = '0;
        if (Cmd_valid) begin
          if (Cmd_press) begin
            state_next = S_PRESS;
          end else if (Cmd_count == '0) begin
            // Empty request: acknowledge completion without touching A/B.
            done_next = 1'b1;
          end else begin
            state_next     = S_PH1;
            remaining_next = Cmd_count;
            dir_next       = Cmd_dir;
          end
        end
      end
      S_PH1, S_PH2, S_PH3, S_PH4: begin
        if (timer == PHASE_LAST) begin
          timer_next = '0;
          case (state)
            S_PH1:   state_next = S_PH2;
            S_PH2:   state_next = S_PH3;
            S_PH3:   state_next = S_PH4;
            default: state_next = S_GAP;
          endcase
        end
      end
      S_GAP: begin
        if (timer == GAP_LAST) begin
          timer_next = '0;
          // A press arrives here with remaining already zero; saturate rather than wrap.
          if (remaining != '0) begin
            remaining_next = remaining - 1'b1;
          end
          if (remaining > CNT_W'(1)) begin
            state_next = S_PH1;
          end else begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      S_PRESS: begin
        // Button is held for one cycle only: the decoder steps on level.
        state_next = S_GAP;
        timer_next = '0;
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase

    a_next = 1'b1;
    b_next = 1'b1;
    case (state_next)
      S_PH1: begin
        a_next = dir_next;
        b_next = ~dir_next;
      end
      S_PH2: begin
        a_next = 1'b0;
        b_next = 1'b0;
      end
      S_PH3: begin
        a_next = ~dir_next;
        b_next = dir_next;
      end
      default: begin
        a_next = 1'b1;
        b_next = 1'b1;
      end
    endcase
    c_next    = (state_next == S_PRESS);
    busy_next = (state_next != S_IDLE);
  end

  // State, timers and registered outputs; reset forces idle levels immediately.
  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      Rot_A     <= 1'b1;
      Rot_B     <= 1'b1;
      Rot_C     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      remaining <= remaining_next;
      dir       <= dir_next;
      Rot_A     <= a_next;
      Rot_B     <= b_next;
      Rot_C     <= c_next;
      Busy      <= busy_next;
      Done      <= done_next;
    end
  end

  assign Cmd_ready = ~Busy;

endmodule

// File: tb/tb_rotary_quad_gen.sv
// Bench for rotary_quad_gen: directed and random commands, every cycle compared with a
// timing model derived from the detent period arithmetic.
module tb_rotary_quad_gen;

  localparam int P     = 64;
  localparam int G     = 512;
  localparam int CNT_W = 8;
  localparam int PER   = 4 * P + G;

  logic             Fg_clk = 1'b0;
  logic             Reset;
  logic             Cmd_valid;
  logic             Cmd_ready;
  logic             Cmd_dir;
  logic [CNT_W-1:0] Cmd_count;
  logic             Cmd_press;
  logic             Rot_A, Rot_B, Rot_C, Busy, Done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int net_detents = 0;
  int c_times[$];
  logic prev_a = 1'b1;
  logic prev_b = 1'b1;

  rotary_quad_gen #(.PHASE_CYCLES(P), .GAP_CYCLES(G), .CNT_W(CNT_W)) dut (
    .Fg_clk   (Fg_clk),
    .Reset    (Reset),
    .Cmd_valid(Cmd_valid),
    .Cmd_ready(Cmd_ready),
    .Cmd_dir  (Cmd_dir),
    .Cmd_count(Cmd_count),
    .Cmd_press(Cmd_press),
    .Rot_A    (Rot_A),
    .Rot_B    (Rot_B),
    .Rot_C    (Rot_C),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Fg_clk = ~Fg_clk;

  // Quadrature observer: B falling while A high is one increase detent, A falling while B high a decrease.
  always @(negedge Fg_clk) begin
    cyc <= cyc + 1;
    if (Rot_C) c_times.push_back(cyc);
    if (prev_b && !Rot_B && Rot_A) net_detents <= net_detents + 1;
    if (prev_a && !Rot_A && Rot_B) net_detents <= net_detents - 1;
    prev_a <= Rot_A;
    prev_b <= Rot_B;
  end

  // Vector layout: {A, B, C, Busy, Ready, Done}
  localparam logic [5:0] V_IDLE = 6'b110010;
  localparam logic [5:0] V_DONE = 6'b110011;

  function automatic int done_offset(input bit press, input int n);
    if (press) return G + 2;
    if (n == 0) return 1;
    return n * PER + 1;
  endfunction

  // Expected outputs j cycles after the acceptance cycle.
  function automatic logic [5:0] exp_vec(input bit dir, input int n, input bit press, input int j);
    bit ia[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit ib[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int k, ph;
    if (j == done_offset(press, n)) return V_DONE;
    if (press) begin
      if (j == 1) return 6'b111100;
      if (j <= G + 1) return 6'b110100;
      return V_IDLE;
    end
    if (n == 0 || j > n * PER) return V_IDLE;
    k  = (j - 1) % PER;
    ph = k / P;
    if (ph >= 4) return 6'b110100;
    // Decrease mirrors increase with A and B swapped.
    if (dir) return {ia[ph], ib[ph], 4'b0100};
    return {ib[ph], ia[ph], 4'b0100};
  endfunction

  function automatic logic [5:0] obs_vec();
    return {Rot_A, Rot_B, Rot_C, Busy, Cmd_ready, Done};
  endfunction

  task automatic check_vec(input string tag, input int j, input logic [5:0] obs, input logic [5:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s j=%0d observed ABC_busy_ready_done=%b expected=%b", tag, j, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one command in the current cycle (known idle) and check up to max_j cycles after it.
  // With tail set, one more idle cycle with Done low is also checked.
  task automatic run_cmd(input string tag, input bit dir, input int n, input bit press,
                         input int max_j, input bit tail);
    int last;
    logic [5:0] ev;
    Cmd_dir   = dir;
    Cmd_count = n[CNT_W-1:0];
    Cmd_press = press;
    Cmd_valid = 1'b1;
    last = done_offset(press, n);
    if (max_j < last) last = max_j;
    for (int j = 1; j <= last; j++) begin
      @(posedge Fg_clk);
      #1;
      ev = exp_vec(dir, n, press, j);
      check_vec(tag, j, obs_vec(), ev);
      // While busy, throw junk requests at the block; they must be ignored.
      if (ev[2] && j < last) begin
        Cmd_valid = 1'($urandom_range(0, 1));
        Cmd_dir   = 1'($urandom_range(0, 1));
        Cmd_count = CNT_W'($urandom_range(0, 255));
        Cmd_press = 1'($urandom_range(0, 1));
      end else begin
        Cmd_valid = 1'b0;
      end
    end
    Cmd_valid = 1'b0;
    if (tail) begin
      @(posedge Fg_clk);
      #1;
      check_vec({tag, "_after"}, last + 1, obs_vec(), V_IDLE);
    end
    $display("cmd %s dir=%0d count=%0d press=%0d checked %0d cycles", tag, dir, n, press, last);
  endtask

  initial begin
    int base;
    bit r_press, r_dir;
    int r_n;

    Reset     = 1'b1;
    Cmd_valid = 1'b0;
    Cmd_dir   = 1'b0;
    Cmd_count = '0;
    Cmd_press = 1'b0;
    repeat (3) @(posedge Fg_clk);
    #1;
    check_vec("reset", 0, obs_vec(), V_IDLE);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Fg_clk);
      #1;
      check_vec("idle_hold", i, obs_vec(), V_IDLE);
    end
    $display("reset and idle hold checked");

    // Three increase detents: Done lands T+1+3*PER.
    run_cmd("inc3", 1'b1, 3, 1'b0, 100000, 1'b1);

    // Decoder-style bookkeeping: 5 -> 3 -> 7.
    base = net_detents;
    run_cmd("dec2", 1'b0, 2, 1'b0, 100000, 1'b1);
    check_int("detents_after_dec2", 5 + net_detents - base, 3);
    run_cmd("inc4", 1'b1, 4, 1'b0, 100000, 1'b1);
    check_int("detents_after_inc4", 5 + net_detents - base, 7);

    // Empty request: Done at T+1 and no A/B edge.
    base = net_detents;
    run_cmd("zero", 1'b1, 0, 1'b0, 100000, 1'b1);
    check_int("zero_no_edges", net_detents - base, 0);

    // Two presses back to back: second accepted in the Done cycle of the first.
    c_times.delete();
    run_cmd("press1", 1'b0, 0, 1'b1, 100000, 1'b0);
    run_cmd("press2", 1'b1, 9, 1'b1, 100000, 1'b1);
    check_int("press_pulses", c_times.size(), 2);
    if (c_times.size() == 2)
      check_int("press_low_cycles_between", c_times[1] - c_times[0] - 1, G + 1);

    // Reset in PH2 of a five-detent run: idle levels at once, no Done afterwards.
    run_cmd("inc5_abort", 1'b1, 5, 1'b0, P + 36, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    check_vec("async_reset", 0, obs_vec(), V_IDLE);
    repeat (2) @(posedge Fg_clk);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Fg_clk);
      #1;
      check_vec("post_reset_idle", i, obs_vec(), V_IDLE);
    end
    run_cmd("inc1_after_reset", 1'b1, 1, 1'b0, 100000, 1'b1);

    // Random commands.
    for (int i = 0; i < 10; i++) begin
      r_press = ($urandom_range(0, 3) == 0);
      r_dir   = 1'($urandom_range(0, 1));
      r_n     = int'($urandom_range(0, 3));
      base    = net_detents;
      run_cmd("rand", r_dir, r_n, r_press, 100000, 1'($urandom_range(0, 1)));
      check_int("rand_detents", net_detents - base, r_press ? 0 : (r_dir ? r_n : -r_n));
    end

    @(posedge Fg_clk);
    #1;
    check_vec("final_idle", 0, obs_vec(), V_IDLE);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
